// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four valid/ready requesters share one registered
// output channel through round-robin arbitration and a mux4.
module mux4 #(
   parameter int N = 1
) (
   input  logic [1:0]   i_sel,
   input  logic [N-1:0] i_d0,
   input  logic [N-1:0] i_d1,
   input  logic [N-1:0] i_d2,
   input  logic [N-1:0] i_d3,
   output logic [N-1:0] o_y
);
   always_comb begin
      case (i_sel)
         2'd0:    o_y = i_d0;
         2'd1:    o_y = i_d1;
         2'd2:    o_y = i_d2;
         default: o_y = i_d3;
      endcase
   end
endmodule

module mux4_rr_arbiter #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   req_valid,
   input  logic [N-1:0] req_data00,
   input  logic [N-1:0] req_data01,
   input  logic [N-1:0] req_data02,
   input  logic [N-1:0] req_data03,
   output logic [3:0]   req_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [1:0]   out_select
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t       r_state;
   logic [N-1:0] r_data;
   logic [1:0]   r_sel;
   logic [1:0]   r_last;

   logic         w_any;
   logic         w_load_en;
   logic [1:0]   w_grant;
   logic [N-1:0] w_mux;

   assign w_any = |req_valid;

   // No handshake may complete while reset is held.
   assign w_load_en = rst_n && w_any &&
                      ((r_state == EMPTY) || out_ready);

   // Scan last+4 down to last+1 so the nearest successor wins.
   always_comb begin
      w_grant = r_last;
      for (int k = 4; k >= 1; k--) begin
         if (req_valid[r_last + 2'(k)]) begin
            w_grant = r_last + 2'(k);
         end
      end
   end

   assign req_ready = w_load_en ? (4'b0001 << w_grant) : 4'b0000;

   mux4 #(.N(N)) u_mux (
      .i_sel (w_grant),
      .i_d0  (req_data00),
      .i_d1  (req_data01),
      .i_d2  (req_data02),
      .i_d3  (req_data03),
      .o_y   (w_mux)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_data  <= '0;
         r_sel   <= 2'd0;
         r_last  <= 2'd3;
      end else if (w_load_en) begin
         r_state <= FULL;
         r_data  <= w_mux;
         r_sel   <= w_grant;
         r_last  <= w_grant;
      end else if ((r_state == FULL) && out_ready) begin
         r_state <= EMPTY;
      end
   end

   assign out_valid  = (r_state == FULL);
   assign out_data   = r_data;
   assign out_select = r_sel;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and random checks against a
// behavioural round-robin model.
module tb_mux4_rr_arbiter;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [N-1:0] req_data00;
   logic [N-1:0] req_data01;
   logic [N-1:0] req_data02;
   logic [N-1:0] req_data03;
   logic [3:0]   req_ready;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic [1:0]   out_select;

   int n_cmp = 0;
   int n_err = 0;

   int           m_last;
   bit           m_full;
   logic [N-1:0] m_data;
   int           m_sel;

   mux4_rr_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data00 (req_data00),
      .req_data01 (req_data01),
      .req_data02 (req_data02),
      .req_data03 (req_data03),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_select (out_select)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int m_grant(input logic [3:0] v);
      for (int k = 1; k <= 4; k++) begin
         if (v[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_full = 0;
      m_data = '0;
      m_sel  = 0;
      m_last = 3;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_full));
      chk({tag, ".data"}, 32'(out_data), 32'(m_data));
      chk({tag, ".sel"}, 32'(out_select), 32'(m_sel));
   endtask

   // One cycle: drive at negedge, check, then advance the model.
   task automatic step(input logic [3:0] v, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] e, input logic rdy,
                       output int g);
      logic [7:0] d [4];
      bit         load;
      logic [3:0] er;
      d[0] = a; d[1] = b; d[2] = c; d[3] = e;
      @(negedge clk);
      req_valid  = v;
      req_data00 = a;
      req_data01 = b;
      req_data02 = c;
      req_data03 = e;
      out_ready  = rdy;
      #1;
      chk_outs("out");
      load = (!m_full || rdy) && (v != 4'd0);
      g = load ? m_grant(v) : -1;
      er = load ? 4'(1 << g) : 4'd0;
      chk("req_ready", 32'(req_ready), 32'(er));
      @(posedge clk);
      if (load) begin
         m_data = d[g];
         m_sel  = g;
         m_last = g;
         m_full = 1;
      end else if (m_full && rdy) begin
         m_full = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 4'hF;
      out_ready = 1'b1;
      #1;
      m_reset();
      chk_outs("rst");
      chk("rst.ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 4'h0;
   endtask

   initial begin
      int g;
      rst_n = 1'b0;
      req_valid = 4'h0;
      req_data00 = '0; req_data01 = '0;
      req_data02 = '0; req_data03 = '0;
      out_ready = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Some traffic, then reset mid-stream and idle.
      step(4'hF, 8'h1, 8'h2, 8'h3, 8'h4, 1'b1, g);
      step(4'hF, 8'h1, 8'h2, 8'h3, 8'h4, 1'b0, g);
      do_reset();
      repeat (3) step(4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1, g);

      // Single requester.
      step(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, g);
      chk("single.grant", 32'(g), 32'd2);
      step(4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b1, g);
      chk("single.data", 32'(out_data), 32'hA5);
      chk("single.sel", 32'(out_select), 32'd2);
      chk("single.grant2", 32'(g), 32'd2);

      // Fairness from reset.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1, g);
         chk("fair.grant", 32'(g), 32'(i % 4));
      end
      step(4'h0, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1, g);

      // Backpressure holding requester 1's word.
      do_reset();
      step(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1, g);
      step(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1, g);
      for (int i = 0; i < 5; i++) begin
         step(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1'b0, g);
         chk("bp.data", 32'(out_data), 32'h11);
         chk("bp.ready", 32'(req_ready), 32'd0);
      end
      step(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1'b1, g);
      chk("bp.next", 32'(g), 32'd2);

      // Drain without refill keeps last=1.
      do_reset();
      step(4'b0010, 8'h0, 8'h77, 8'h0, 8'h0, 1'b1, g);
      step(4'b0000, 8'h0, 8'h77, 8'h0, 8'h0, 1'b1, g);
      step(4'b0000, 8'h0, 8'h77, 8'h0, 8'h0, 1'b1, g);
      chk("drain.valid", 32'(out_valid), 32'd0);
      chk("drain.hold", 32'(out_data), 32'h77);
      step(4'b1001, 8'h50, 8'h0, 8'h0, 8'h53, 1'b1, g);
      chk("drain.grant", 32'(g), 32'd3);

      // Sparse rotation.
      do_reset();
      step(4'b0001, 8'h60, 8'h61, 8'h0, 8'h0, 1'b1, g);
      step(4'b0001, 8'h60, 8'h61, 8'h0, 8'h0, 1'b1, g);
      chk("sparse.g0", 32'(g), 32'd0);
      step(4'b0011, 8'h60, 8'h61, 8'h0, 8'h0, 1'b1, g);
      chk("sparse.g1", 32'(g), 32'd1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            step(4'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), g);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one N-bit output channel between four valid/ready requesters. It picks a winner each cycle the output register can accept data, steers the winner's data through an internal `mux4` (same `N`), and captures it into a single registered output stage. Used wherever four cell/row producers in the Game of Life datapath feed one consumer.

## Interface

**Parameters**

- `N`, default 1: data width of every requester and the output.

**Ports**

- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, 4: bit i set means requester i has data.
- `req_data00`, `req_data01`, `req_data02`, `req_data03`, input, N each: requester payloads.
- `req_ready`, output, 4: one-hot or zero; bit i set means requester i's data is taken this cycle.
- `out_valid`, output, 1: output register holds data.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.
- `out_data`, output, N: registered payload.
- `out_select`, output, 2: index of the requester whose data is in `out_data`.

## Operation

- Output stage has two states, tracked by `out_valid`.
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `load_en` = (!`out_valid` || `out_ready`) && |`req_valid`.
- Arbitration is combinational from `req_valid` and the `last` pointer (2 bits).
  - Priority order is `last`+1, `last`+2, `last`+3, `last`, all mod 4.
  - `grant` is the first index in that order with `req_valid` set.
- `req_ready[i]` = `load_en` && (`grant`==i).
  - At most one bit is set.
  - `req_ready` never depends on `req_data`.
- When `load_en` is high, on the clock edge:
  - `out_data` takes the `mux4` output, with select=`grant`.
  - `out_select` takes `grant`.
  - `last` takes `grant`.
  - `out_valid` takes 1.
- When `out_valid` && `out_ready` && !(|`req_valid`):
  - `out_valid` goes to 0.
  - `out_data`, `out_select` and `last` hold their values.
- When `out_valid` && !`out_ready`:
  - All registers hold.
  - `req_ready` is 0.
  - Requesters must hold `req_valid` and data stable until accepted.
- Simultaneous drain and refill (FULL, `out_ready`=1, some `req_valid`): the old word leaves and the new word loads on the same edge. `out_valid` stays 1, giving full throughput.
- `last` advances only on an accepted grant. Idle cycles and stall cycles do not rotate priority.
- A requester that drops `req_valid` before it is granted loses nothing. Arbitration re-evaluates every cycle.

## Timing

- Reset values (while `rst_n`=0, applied asynchronously):
  - `out_valid`=0, `out_data`=0, `out_select`=0.
  - `last`=3, so requester 0 has first priority.
  - `req_ready`=0.
- Reset asserted mid-transfer discards the held word. No handshake completes in a reset cycle.
- Latency: a word accepted at edge k (`req_ready` high in the cycle before k) appears on `out_data` with `out_valid`=1 right after edge k.
- Throughput: one word per cycle when `out_ready` is held high.
- Fairness: with all four `req_valid` held high and `out_ready`=1, grants are strictly periodic 0,1,2,3,0,…
  - Each requester waits at most 3 accepted transfers.
- Combinational paths:
  - `req_valid` and `out_ready` drive `req_ready`.
  - There is no path from `out_ready` to `out_valid` or `out_data`; those are registered.

## Test plan

- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-stream, release it, keep `req_valid`=0.
  - Required: `out_valid`=0, `out_data`=0, `out_select`=0, `req_ready`=0 throughout.
- Single requester:
  - Stimulus: N=8, `req_valid`=4'b0100, `req_data02`=8'hA5, `out_ready`=1.
  - Required: `req_ready`=4'b0100 in the first cycle. The next cycle shows `out_data`=8'hA5, `out_select`=2, `out_valid`=1. Then one transfer per cycle while valid is held.
- Round-robin fairness:
  - Stimulus: `req_valid`=4'b1111 with data 8'h10, 8'h11, 8'h12, 8'h13, and `out_ready`=1 for 8 cycles.
  - Required: `out_select` sequence 0,1,2,3,0,1,2,3 and `out_data` 8'h10..8'h13 repeating.
- Backpressure:
  - Stimulus: FULL holding 8'h11 from requester 1, `out_ready`=0 for 5 cycles, `req_valid`=4'b1111.
  - Required: `req_ready`=0 and `out_data`=8'h11 unchanged. When `out_ready` rises, the next grant is requester 2.
- Drain without refill:
  - Stimulus: FULL, `out_ready`=1, `req_valid`=0.
  - Required: `out_valid`=0 next cycle. `last` unchanged, so a subsequent `req_valid`=4'b1001 with `last`=1 grants requester 3.
- Sparse rotation:
  - Stimulus: `last`=0, `req_valid`=4'b0001 then 4'b0011.
  - Required: grant 0 first (only requester). Then grant 1, because 1 precedes 0 in the order after `last`=0.
